// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

   localparam int RELOCK_W = 8;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } pll_sup_state_t;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, async active-low reset.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the raw input through the flop chain; only the last stage is used.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies lock stability and
// holds the core in reset until the PLL has been continuously locked.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   PLL_RST   | pll_rst held high for PLL_RST_CYCLES
//   WAIT_LOCK | PLL released, waiting for lock, bounded by the lock timeout
//   STABLE    | lock seen, counting consecutive locked cycles
//   RUN       | lock qualified, core reset released, ready high
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int SYNC_STAGES         = 2,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int CNT_W               = 16
) (
   input  logic                refclk,
   input  logic                rst_n,
   input  logic                pll_locked,
   input  logic                clear_err,
   output logic                pll_rst,
   output logic                sys_reset,
   output logic                ready,
   output logic [RELOCK_W-1:0] relock_count,
   output logic                timeout_err
);

   localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES
                                                                   : LOCK_TIMEOUT_CYCLES;
   localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
   localparam longint unsigned CNT_CAP = (64'd1 << CNT_W) - 64'd1;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

   if ((64'(MAX_CYC) - 64'd1) > CNT_CAP) begin : g_cnt_too_narrow
      $error("pll_lock_supervisor: CNT_W too narrow for the largest cycle parameter");
   end
   if (SYNC_STAGES < 2 || PLL_RST_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 ||
       LOCK_STABLE_CYCLES < 1) begin : g_bad_param
      $error("pll_lock_supervisor: parameter below its minimum");
   end

   pll_sup_state_t    state;
   logic [CNT_W-1:0]  cnt;
   logic              locked_s;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_sync_locked (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   // Sequencer: state, shared phase counter and all registered outputs.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= PLL_RST;
         cnt          <= '0;
         pll_rst      <= 1'b1;
         sys_reset    <= 1'b1;
         ready        <= 1'b0;
         relock_count <= '0;
         timeout_err  <= 1'b0;
      end else begin
         // A timeout set below overrides this clear in the same cycle.
         if (clear_err) begin
            timeout_err <= 1'b0;
         end

         case (state)
            PLL_RST: begin
               if (cnt == RST_LAST) begin
                  state   <= WAIT_LOCK;
                  cnt     <= '0;
                  pll_rst <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            WAIT_LOCK: begin
               if (locked_s) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  state       <= PLL_RST;
                  cnt         <= '0;
                  pll_rst     <= 1'b1;
                  timeout_err <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            STABLE: begin
               // Losing lock while qualifying is treated as a glitch: no error,
               // just restart the wait without re-resetting the PLL.
               if (!locked_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state     <= RUN;
                  cnt       <= '0;
                  sys_reset <= 1'b0;
                  ready     <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            RUN: begin
               if (!locked_s) begin
                  state     <= PLL_RST;
                  cnt       <= '0;
                  pll_rst   <= 1'b1;
                  sys_reset <= 1'b1;
                  ready     <= 1'b0;
                  if (relock_count != '1) begin
                     relock_count <= relock_count + RELOCK_W'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios with
// arithmetic expectations plus randomized lock patterns against a phase model.
module tb_pll_lock_supervisor;

   localparam int SYNC = 2;
   localparam int PRST = 4;
   localparam int TO   = 20;
   localparam int ST   = 8;

   logic       refclk;
   logic       rst_n;
   logic       pll_locked;
   logic       clear_err;
   logic       pll_rst;
   logic       sys_reset;
   logic       ready;
   logic [7:0] relock_count;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;

   pll_lock_supervisor #(
      .SYNC_STAGES         (SYNC),
      .PLL_RST_CYCLES      (PRST),
      .LOCK_TIMEOUT_CYCLES (TO),
      .LOCK_STABLE_CYCLES  (ST),
      .CNT_W               (16)
   ) dut (
      .refclk       (refclk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .clear_err    (clear_err),
      .pll_rst      (pll_rst),
      .sys_reset    (sys_reset),
      .ready        (ready),
      .relock_count (relock_count),
      .timeout_err  (timeout_err)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   // Reference model: phase 0 = PLL held in reset, 1 = waiting for lock,
   // 2 = qualifying, 3 = running. m_age = edges spent in the current phase.
   int m_phase;
   int m_age;
   int m_relocks;
   bit m_err;
   bit m_hist [SYNC];

   always @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase   = 0;
         m_age     = 0;
         m_relocks = 0;
         m_err     = 1'b0;
         for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
      end else begin
         bit ls;
         ls = m_hist[SYNC-1];
         for (int i = SYNC-1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = pll_locked;
         if (clear_err) m_err = 1'b0;
         m_age++;
         case (m_phase)
            0: if (m_age == PRST) begin m_phase = 1; m_age = 0; end
            1: begin
               if (ls) begin m_phase = 2; m_age = 0; end
               else if (m_age == TO) begin m_phase = 0; m_age = 0; m_err = 1'b1; end
            end
            2: begin
               if (!ls) begin m_phase = 1; m_age = 0; end
               else if (m_age == ST) begin m_phase = 3; m_age = 0; end
            end
            default: begin
               if (!ls) begin
                  m_phase = 0;
                  m_age   = 0;
                  if (m_relocks < 255) m_relocks++;
               end
            end
         endcase
      end
   end

   // Waits up to budget edges for pll_rst (which=0) or ready (which=1) to
   // equal val; n = edge count, or -1 if the budget expired.
   task automatic wait_sig(input int which, input logic val, input int budget,
                           output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge refclk);
         #1;
         if (((which == 0) ? pll_rst : ready) === val) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      clear_err = 1'b0;
      #23;
      @(negedge refclk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      int n;
      pll_locked = 1'b1;
      clear_err  = 1'b0;
      rst_n      = 1'b0;
      #12;
      checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL rst_pll_rst: got %b want 1", pll_rst); end
      checks++; if (sys_reset !== 1'b1) begin errors++; $display("FAIL rst_sys_reset: got %b want 1", sys_reset); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ready); end
      checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL rst_relock: got %0d want 0", relock_count); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
      @(negedge refclk);
      rst_n = 1'b1;
      wait_sig(0, 1'b0, 50, n);
      checks++; if (n != PRST) begin errors++; $display("FAIL pll_rst_release_edges: got %0d want %0d", n, PRST); end
      // Lock was already through the synchronizer at WAIT_LOCK entry.
      wait_sig(1, 1'b1, 60, n);
      checks++; if (n != 1 + ST) begin errors++; $display("FAIL ready_edges_locked_throughout: got %0d want %0d", n, 1 + ST); end
      checks++; if (sys_reset !== 1'b0) begin errors++; $display("FAIL run_sys_reset: got %b want 0", sys_reset); end
      checks++; if (relock_count !== 8'd0 || timeout_err !== 1'b0) begin errors++; $display("FAIL run_status: relock %0d err %b want 0 0", relock_count, timeout_err); end

      // Lock rising at WAIT_LOCK entry: ready on edge SYNC+1+ST.
      pll_locked = 1'b0;
      apply_reset();
      wait_sig(0, 1'b0, 50, n);
      pll_locked = 1'b1;
      wait_sig(1, 1'b1, 60, n);
      checks++; if (n != SYNC + 1 + ST) begin errors++; $display("FAIL ready_edges_after_rise: got %0d want %0d", n, SYNC + 1 + ST); end
   endtask

   task automatic test_timeout();
      int n, n_fall, n_rise;
      pll_locked = 1'b0;
      apply_reset();
      wait_sig(0, 1'b0, 50, n);
      wait_sig(0, 1'b1, 100, n);
      checks++; if (n != TO) begin errors++; $display("FAIL timeout_edges: got %0d want %0d", n, TO); end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %b want 1", timeout_err); end
      wait_sig(0, 1'b0, 50, n_fall);
      wait_sig(0, 1'b1, 100, n_rise);
      checks++; if (n_fall + n_rise != PRST + TO) begin errors++; $display("FAIL timeout_period: got %0d want %0d", n_fall + n_rise, PRST + TO); end
      checks++; if (ready !== 1'b0 || sys_reset !== 1'b1) begin errors++; $display("FAIL timeout_core_held: ready %b sys_reset %b want 0 1", ready, sys_reset); end
   endtask

   task automatic test_glitch();
      int n;
      pll_locked = 1'b0;
      apply_reset();
      wait_sig(0, 1'b0, 50, n);
      pll_locked = 1'b1;
      repeat (5) @(posedge refclk);
      #1;
      pll_locked = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge refclk);
         #1;
         checks++; if (ready !== 1'b0 || pll_rst !== 1'b0) begin errors++; $display("FAIL glitch_quiet: ready %b pll_rst %b want 0 0", ready, pll_rst); end
      end
      pll_locked = 1'b1;
      wait_sig(1, 1'b1, 60, n);
      checks++; if (n != SYNC + 1 + ST) begin errors++; $display("FAIL glitch_requalify_edges: got %0d want %0d", n, SYNC + 1 + ST); end
      checks++; if (timeout_err !== 1'b0 || relock_count !== 8'd0) begin errors++; $display("FAIL glitch_no_error: err %b relock %0d want 0 0", timeout_err, relock_count); end
   endtask

   task automatic test_lock_loss_run();
      int n;
      pll_locked = 1'b0;
      wait_sig(1, 1'b0, 20, n);
      checks++; if (n != SYNC + 1) begin errors++; $display("FAIL loss_edges: got %0d want %0d", n, SYNC + 1); end
      checks++; if (sys_reset !== 1'b1 || pll_rst !== 1'b1) begin errors++; $display("FAIL loss_resets: sys_reset %b pll_rst %b want 1 1", sys_reset, pll_rst); end
      checks++; if (relock_count !== 8'd1) begin errors++; $display("FAIL loss_relock: got %0d want 1", relock_count); end
      pll_locked = 1'b1;
      wait_sig(1, 1'b1, 60, n);
      checks++; if (n != PRST + 1 + ST) begin errors++; $display("FAIL loss_return_edges: got %0d want %0d", n, PRST + 1 + ST); end
   endtask

   task automatic test_saturation_and_clear();
      int n;
      pll_locked = 1'b1;
      apply_reset();
      wait_sig(1, 1'b1, 60, n);
      for (int i = 0; i < 260; i++) begin
         pll_locked = 1'b0;
         wait_sig(1, 1'b0, 20, n);
         pll_locked = 1'b1;
         wait_sig(1, 1'b1, 60, n);
         if (n < 0) begin
            checks++; errors++;
            $display("FAIL sat_relock_timeout: got no ready at loss %0d want ready", i);
            break;
         end
         if (i == 0 || i == 254) begin
            checks++; if (relock_count !== 8'(i + 1)) begin errors++; $display("FAIL sat_relock_step: got %0d want %0d", relock_count, i + 1); end
         end
      end
      checks++; if (relock_count !== 8'd255) begin errors++; $display("FAIL sat_relock_final: got %0d want 255", relock_count); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL sat_no_timeout: got %b want 0", timeout_err); end

      // Clear pulse landing on the same edge as a timeout.
      pll_locked = 1'b0;
      wait_sig(0, 1'b1, 20, n);
      wait_sig(0, 1'b0, 20, n);
      repeat (TO - 1) @(posedge refclk);
      #1;
      checks++; if (pll_rst !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL pre_timeout: pll_rst %b err %b want 0 0", pll_rst, timeout_err); end
      clear_err = 1'b1;
      @(posedge refclk);
      #1;
      clear_err = 1'b0;
      checks++; if (pll_rst !== 1'b1 || timeout_err !== 1'b1) begin errors++; $display("FAIL set_wins: pll_rst %b err %b want 1 1", pll_rst, timeout_err); end
      repeat (3) @(posedge refclk);
      #1;
      clear_err = 1'b1;
      @(posedge refclk);
      #1;
      clear_err = 1'b0;
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b want 0", timeout_err); end
      checks++; if (relock_count !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", relock_count); end
   endtask

   task automatic test_async_reset();
      int n;
      pll_locked = 1'b1;
      wait_sig(1, 1'b1, 80, n);
      checks++; if (n < 0) begin errors++; $display("FAIL async_reach_run: got %0d want >0", n); end
      @(posedge refclk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (pll_rst !== 1'b1 || sys_reset !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL async_ctrl: pll_rst %b sys_reset %b ready %b want 1 1 0", pll_rst, sys_reset, ready); end
      checks++; if (relock_count !== 8'd0 || timeout_err !== 1'b0) begin errors++; $display("FAIL async_status: relock %0d err %b want 0 0", relock_count, timeout_err); end
      #10;
      @(negedge refclk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      pll_locked = 1'b0;
      apply_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge refclk);
         checks++; if (pll_rst !== (m_phase == 0)) begin errors++; $display("FAIL rnd_pll_rst cyc %0d: got %b want %b", cyc, pll_rst, (m_phase == 0)); end
         checks++; if (ready !== (m_phase == 3) || sys_reset !== (m_phase != 3)) begin errors++; $display("FAIL rnd_ready cyc %0d: ready %b sys_reset %b want phase %0d", cyc, ready, sys_reset, m_phase); end
         checks++; if (relock_count !== 8'(m_relocks)) begin errors++; $display("FAIL rnd_relock cyc %0d: got %0d want %0d", cyc, relock_count, m_relocks); end
         checks++; if (timeout_err !== m_err) begin errors++; $display("FAIL rnd_timeout_err cyc %0d: got %b want %b", cyc, timeout_err, m_err); end
         if (hold == 0) begin
            pll_locked = 1'($urandom_range(0, 1));
            hold = pll_locked ? $urandom_range(1, 40) : $urandom_range(1, 30);
         end
         hold--;
         clear_err = ($urandom_range(0, 15) == 0);
      end
      clear_err = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      clear_err  = 1'b0;
      test_reset();
      test_timeout();
      test_glitch();
      test_lock_loss_run();
      test_saturation_and_clear();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
